// File: rtl/imm_extend_pipe.sv
// Buffered immediate extender: extends in_imm per in_sel at push time and queues {data, err} in a small FIFO.
// Optional macro IMM_EXT_BRANCH_EN enables the word-shifted branch-offset form for sel 6/7.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_sel,
  input  logic [IN_W-1:0]            in_imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_err,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int E  = OUT_W - IN_W;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [OUT_W-1:0] r_mem_data [DEPTH];
  logic             r_mem_err  [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_ext;
  logic             w_err;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  assign w_zext = {{E{1'b0}}, in_imm};
  assign w_sext = {{E{in_imm[IN_W-1]}}, in_imm};

  always_comb begin
    w_ext = w_zext;
    w_err = 1'b0;
    case (in_sel)
      4'd0, 4'd1: w_ext = w_zext;
      4'd2, 4'd3: w_ext = w_sext;
      4'd4, 4'd5: w_ext = {in_imm, {E{1'b0}}};
`ifdef IMM_EXT_BRANCH_EN
      // shifting the sign-extended value keeps E-2 sign bits even when E == 2
      4'd6, 4'd7: w_ext = w_sext << 2;
`else
      4'd6, 4'd7: begin
        w_ext = w_zext;
        w_err = 1'b1;
      end
`endif
      default: begin
        w_ext = w_zext;
        w_err = 1'b1;
      end
    endcase
  end

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_push  = in_valid && !w_full;
  assign w_pop   = out_ready && !w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_err[i]  <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= w_ext;
        r_mem_err[r_wr_ptr]  <= w_err;
        r_wr_ptr             <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign out_data  = r_mem_data[r_rd_ptr];
  assign out_err   = r_mem_err[r_rd_ptr];
  assign count     = r_count;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed + random bench for imm_extend_pipe against a queue-based reference model.
// Expectations for sel 6/7 follow IMM_EXT_BRANCH_EN as defined for the build.
module tb_imm_extend_pipe;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;
  localparam int DEPTH = 2;
  localparam int E     = OUT_W - IN_W;

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [3:0]              in_sel;
  logic [IN_W-1:0]         in_imm;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_W-1:0]        out_data;
  logic                    out_err;
  logic [$clog2(DEPTH):0]  count;

  imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint d;
    bit     e;
  } ent_t;

  ent_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Reference extension from the mode rules, using plain integer arithmetic.
  function automatic void ref_ext(input int sel, input longint imm, output longint d, output bit e);
    longint modv = 64'd1 << OUT_W;
    longint sx;
    sx = (imm >= (64'd1 << (IN_W - 1))) ? imm + modv - (64'd1 << IN_W) : imm;
    d = imm;
    e = 1'b0;
    if (sel <= 1)      d = imm;
    else if (sel <= 3) d = sx;
    else if (sel <= 5) d = (imm * (64'd1 << E)) % modv;
    else if (sel <= 7) begin
`ifdef IMM_EXT_BRANCH_EN
      d = (sx * 4) % modv;
`else
      e = 1'b1;
`endif
    end else e = 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; the model advances and all outputs are checked after the edge.
  task automatic step(input bit r, input bit v, input logic [3:0] s, input logic [IN_W-1:0] im, input bit ordy);
    bit     push, pop;
    longint d;
    bit     e;
    ent_t   ent;
    rst = r; in_valid = v; in_sel = s; in_imm = im; out_ready = ordy;
    push = !r && v && (q.size() < DEPTH);
    pop  = !r && ordy && (q.size() > 0);
    ref_ext(int'(s), longint'(im), d, e);
    @(posedge clk);
    #1;
    if (r) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        ent.d = d; ent.e = e;
        q.push_back(ent);
      end
    end
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    chk("count", 64'(count), 64'(q.size()));
    if (q.size() > 0) begin
      chk("out_data", 64'(out_data), 64'(q[0].d));
      chk("out_err", 64'(out_err), 64'(q[0].e));
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_imm = '0; out_ready = 1'b0;

    // reset held with a pending push
    step(1, 1, 4'd0, 16'h1234, 0);
    step(1, 1, 4'd0, 16'h1234, 0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    step(0, 0, 4'd0, 16'h0, 0);
    chk("rst_release_count", 64'(count), 64'd0);

    // modes, each visible one cycle after its push
    step(0, 1, 4'd0, 16'h8001, 1);
    chk("sel0", 64'(out_data), 64'h0000_8001);
    chk("sel0_err", 64'(out_err), 64'd0);
    step(0, 1, 4'd3, 16'h8001, 1);
    chk("sel3", 64'(out_data), 64'hFFFF_8001);
    step(0, 1, 4'd5, 16'h8001, 1);
    chk("sel5", 64'(out_data), 64'h8001_0000);
    chk("sel5_err", 64'(out_err), 64'd0);
    step(0, 1, 4'd6, 16'h8001, 1);
`ifdef IMM_EXT_BRANCH_EN
    chk("sel6", 64'(out_data), 64'hFFFE_0004);
    chk("sel6_err", 64'(out_err), 64'd0);
`else
    chk("sel6", 64'(out_data), 64'h0000_8001);
    chk("sel6_err", 64'(out_err), 64'd1);
`endif
    step(0, 1, 4'd12, 16'h8001, 1);
    chk("sel12", 64'(out_data), 64'h0000_8001);
    chk("sel12_err", 64'(out_err), 64'd1);
    step(0, 0, 4'd0, 16'h0, 1);
    chk("drained", 64'(out_valid), 64'd0);

    // full and backpressure
    step(0, 1, 4'd0, 16'h0001, 0);
    step(0, 1, 4'd0, 16'h0002, 0);
    chk("full_count", 64'(count), 64'd2);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    step(0, 1, 4'd0, 16'h0003, 0);
    chk("full_reject_count", 64'(count), 64'd2);
    chk("full_head_hold", 64'(out_data), 64'h0000_0001);
    step(0, 0, 4'd0, 16'h0, 0);
    chk("full_head_hold2", 64'(out_data), 64'h0000_0001);
    step(0, 0, 4'd0, 16'h0, 1);
    chk("drain_second", 64'(out_data), 64'h0000_0002);
    step(0, 0, 4'd0, 16'h0, 1);
    chk("drain_empty", 64'(out_valid), 64'd0);

    // simultaneous push/pop at count=1, then 20 back-to-back for pointer wrap
    step(0, 1, 4'd2, 16'h00AA, 0);
    step(0, 1, 4'd2, 16'hF0BB, 1);
    chk("pp_count", 64'(count), 64'd1);
    chk("pp_head", 64'(out_data), 64'hFFFF_F0BB);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 4'($urandom_range(0, 15)), 16'($urandom), 1);
      chk("b2b_in_ready", 64'(in_ready), 64'd1);
    end

    // reset with two queued entries
    step(0, 1, 4'd0, 16'h0055, 0);
    chk("pre_rst_count", 64'(count), 64'd2);
    step(1, 1, 4'd0, 16'h0066, 1);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 4'd0, 16'h0, 1);
    chk("post_rst_valid", 64'(out_valid), 64'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0),
           4'($urandom_range(0, 15)), 16'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
